washer_plant: RTL

Behavioural plant model of the washing machine, closing the loop around `state_machine`. It consumes the controller's actuator outputs (`valve`, `shake_mode`, `turn_mode`) and produces the sensor inputs the controller expects (`full`, `Time`, `dry`). It tracks water level, wash time and spin time with counters, so the bench reacts to the controller instead of replaying a fixed `source` stimulus. It also flags illegal actuator combinations.

---
 rtl/washer_plant.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/washer_plant.sv
// washer_plant
// Behavioural plant model of a washing machine that closes the loop around
// the sequencing controller. It turns the actuator commands into the sensor
// levels the controller waits on. A water-level counter is filled by the
// valve and drained by spinning. A wash timer counts agitation while the drum
// is full. A spin timer counts spinning once the drum is empty. A sticky flag
// records any illegal actuator combination.
//
// Parameters
//   FILL_CYCLES  valve edges to fill from empty; also the maximum level
//   WASH_CYCLES  qualifying agitation edges before Time asserts
//   SPIN_CYCLES  qualifying spin edges at empty level before dry asserts
//
// Ports
//   clock       in   single clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   valve       in   fill valve open
//   shake_mode  in   agitate (wash) command
//   turn_mode   in   spin/drain command
//   full        out  level equals FILL_CYCLES
//   Time        out  wash time elapsed (level)
//   dry         out  spin complete (level)
//   fault       out  sticky illegal-command flag, cleared only by reset
//
// Phase tracker (debug view of the commands; it also holds the fault flag)
//   phase     | meaning
//   ----------+---------------------------------------------------
//   PH_IDLE   | no command asserted
//   PH_FILL   | valve open
//   PH_WASH   | agitating
//   PH_SPIN   | spinning / draining
//   PH_FAULT  | two or more commands were seen together; held until reset

module washer_plant #(
   parameter int FILL_CYCLES = 8,
   parameter int WASH_CYCLES = 16,
   parameter int SPIN_CYCLES = 12
) (
   input  logic clock,
   input  logic reset_n,
   input  logic valve,
   input  logic shake_mode,
   input  logic turn_mode,
   output logic full,
   output logic Time,
   output logic dry,
   output logic fault
);

   localparam int LW = $clog2(FILL_CYCLES + 1);
   localparam int WW = (WASH_CYCLES > 1) ? $clog2(WASH_CYCLES) : 1;
   localparam int SW = (SPIN_CYCLES > 1) ? $clog2(SPIN_CYCLES) : 1;

   localparam logic [LW-1:0] LVL_MAX = LW'(FILL_CYCLES);
   localparam logic [WW-1:0] W_LAST  = WW'(WASH_CYCLES - 1);
   localparam logic [SW-1:0] S_LAST  = SW'(SPIN_CYCLES - 1);

   typedef enum logic [2:0] {
      PH_IDLE  = 3'd0,
      PH_FILL  = 3'd1,
      PH_WASH  = 3'd2,
      PH_SPIN  = 3'd3,
      PH_FAULT = 3'd4
   } phase_t;

   phase_t          phase_q, phase_nxt;
   logic [LW-1:0]   level_q, level_nxt;
   logic [WW-1:0]   wcnt_q, wcnt_nxt;
   logic [SW-1:0]   scnt_q, scnt_nxt;
   logic            time_q, time_nxt;
   logic            dry_q, dry_nxt;
   logic            illegal;
   logic            wash_qual;
   logic            spin_qual;

   assign illegal = (valve & shake_mode) | (valve & turn_mode) | (shake_mode & turn_mode);

   // Both qualifiers use the pre-edge level, so full/empty take effect one
   // edge after the level reaches them.
   assign wash_qual = shake_mode & full & ~time_q;
   assign spin_qual = turn_mode & (level_q == '0) & ~dry_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         phase_q <= PH_IDLE;
      end else begin
         phase_q <= phase_nxt;
      end
   end

   always_comb begin
      phase_nxt = PH_IDLE;
      if (phase_q == PH_FAULT || illegal) begin
         phase_nxt = PH_FAULT;
      end else if (valve) begin
         phase_nxt = PH_FILL;
      end else if (shake_mode) begin
         phase_nxt = PH_WASH;
      end else if (turn_mode) begin
         phase_nxt = PH_SPIN;
      end
   end

   // The valve wins over draining when both are commanded.
   always_comb begin
      level_nxt = level_q;
      if (valve) begin
         if (level_q != LVL_MAX) begin
            level_nxt = level_q + LW'(1);
         end
      end else if (turn_mode) begin
         if (level_q != '0) begin
            level_nxt = level_q - LW'(1);
         end
      end
   end

   always_comb begin
      wcnt_nxt = wcnt_q;
      time_nxt = time_q;
      if (!shake_mode) begin
         wcnt_nxt = '0;
         time_nxt = 1'b0;
      end else if (wash_qual) begin
         if (wcnt_q == W_LAST) begin
            wcnt_nxt = '0;
            time_nxt = 1'b1;
         end else begin
            wcnt_nxt = wcnt_q + WW'(1);
         end
      end
   end

   always_comb begin
      scnt_nxt = scnt_q;
      dry_nxt  = dry_q;
      if (!turn_mode) begin
         scnt_nxt = '0;
         dry_nxt  = 1'b0;
      end else if (spin_qual) begin
         if (scnt_q == S_LAST) begin
            scnt_nxt = '0;
            dry_nxt  = 1'b1;
         end else begin
            scnt_nxt = scnt_q + SW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         level_q <= '0;
         wcnt_q  <= '0;
         scnt_q  <= '0;
         time_q  <= 1'b0;
         dry_q   <= 1'b0;
      end else begin
         level_q <= level_nxt;
         wcnt_q  <= wcnt_nxt;
         scnt_q  <= scnt_nxt;
         time_q  <= time_nxt;
         dry_q   <= dry_nxt;
      end
   end

   assign full  = (level_q == LVL_MAX);
   assign Time  = time_q;
   assign dry   = dry_q;
   assign fault = (phase_q == PH_FAULT);

endmodule
